// File: rtl/ftq_gen2.sv
// Fetch target queue: buffers predicted fetch blocks from the BPU, issues them to the
// icache (with an empty-queue bypass), absorbs backend branch writebacks and drains
// committed entries through an FTB update handshake.
module ftq_gen2 #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned XLEN     = 64,
    parameter int unsigned RD_PORTS = 2,
    parameter int unsigned WB_PORTS = 2,
    parameter int unsigned ROB_W    = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_squash_vld,
    input  logic                       i_falsepred,
    input  logic [$clog2(DEPTH)-1:0]   i_recovery_idx,
    input  logic [XLEN-1:0]            i_recovery_npc,
    input  logic                       i_pred_req,
    output logic                       o_ftq_rdy,
    input  logic [XLEN-1:0]            i_pred_start,
    input  logic [XLEN-1:0]            i_pred_end,
    input  logic [XLEN-1:0]            i_pred_target,
    input  logic                       i_pred_taken,
    input  logic                       i_pred_hit,
    input  logic [1:0]                 i_pred_ctr,
    output logic                       o_fetch_req,
    output logic [$clog2(DEPTH)-1:0]   o_fetch_idx,
    input  logic                       i_fetch_rdy,
    output logic [XLEN-1:0]            o_fetch_start,
    output logic [XLEN-1:0]            o_fetch_next,
    output logic [6:0]                 o_fetch_size,
    input  logic [$clog2(DEPTH)-1:0]   i_read_idx   [RD_PORTS],
    output logic [XLEN-1:0]            o_read_start [RD_PORTS],
    output logic [XLEN-1:0]            o_read_next  [RD_PORTS],
    input  logic [WB_PORTS-1:0]        i_wb_vld,
    input  logic [$clog2(DEPTH)-1:0]   i_wb_idx     [WB_PORTS],
    input  logic [ROB_W-1:0]           i_wb_rob     [WB_PORTS],
    input  logic                       i_wb_mispred [WB_PORTS],
    input  logic                       i_wb_taken   [WB_PORTS],
    input  logic [XLEN-1:0]            i_wb_target  [WB_PORTS],
    input  logic                       i_commit_vld,
    input  logic [$clog2(DEPTH):0]     i_commit_ptr,
    output logic                       o_upd_vld,
    input  logic                       i_upd_done,
    output logic [XLEN-1:0]            o_upd_start,
    output logic [XLEN-1:0]            o_upd_target,
    output logic                       o_upd_taken,
    output logic [1:0]                 o_upd_ctr,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    typedef logic [IDX_W:0]   ptr_t;
    typedef logic [IDX_W-1:0] idx_t;

    // Entry storage; size is kept as the 7-bit end-start difference.
    logic [XLEN-1:0]  ent_start   [DEPTH];
    logic [XLEN-1:0]  ent_target  [DEPTH];
    logic [XLEN-1:0]  ent_next    [DEPTH];
    logic [6:0]       ent_size    [DEPTH];
    logic             ent_taken   [DEPTH];
    logic             ent_hit     [DEPTH];
    logic             ent_mispred [DEPTH];
    logic [1:0]       ent_ctr     [DEPTH];
    logic [ROB_W-1:0] ent_rob     [DEPTH];

    ptr_t pred_q, fetch_q, head_q, thre_q;

    ptr_t          count;
    logic          full, enq, bypass, fetch_fire;
    idx_t          fetch_idx, head_idx, rec_low;
    ptr_t          rec_ptr;
    logic          cand, train, pop;
    logic [1:0]    new_ctr;
    logic [WB_PORTS-1:0] wb_elig, wb_win;

    // ROB age compare with wrap bit: true when a is older than b.
    function automatic logic older(input logic [ROB_W-1:0] a, input logic [ROB_W-1:0] b);
        if (a[ROB_W-1] != b[ROB_W-1]) return a[ROB_W-2:0] > b[ROB_W-2:0];
        else                          return a[ROB_W-2:0] < b[ROB_W-2:0];
    endfunction

    // Occupancy, enqueue qualification and fetch issue (bypass when queue is drained).
    always_comb begin
        count      = pred_q - head_q;
        full       = (count == ptr_t'(DEPTH));
        o_ftq_rdy  = ~full;
        o_count    = count;
        enq        = i_pred_req & ~full & ~i_falsepred & ~i_squash_vld;
        bypass     = enq & (fetch_q == pred_q);
        fetch_idx  = fetch_q[IDX_W-1:0];
        o_fetch_req = (fetch_q != pred_q) | bypass;
        o_fetch_idx = fetch_idx;
        if (bypass) begin
            o_fetch_start = i_pred_start;
            o_fetch_next  = i_pred_taken ? i_pred_target : i_pred_end;
            o_fetch_size  = i_pred_end[6:0] - i_pred_start[6:0];
        end else begin
            o_fetch_start = ent_start[fetch_idx];
            o_fetch_next  = ent_next[fetch_idx];
            o_fetch_size  = ent_size[fetch_idx];
        end
        fetch_fire = o_fetch_req & i_fetch_rdy;
    end

    // Recovery pointer: entry after i_recovery_idx, wrap bit chosen to lie in (head, pred].
    always_comb begin
        rec_low = i_recovery_idx + idx_t'(1);
        if (rec_low > head_q[IDX_W-1:0]) rec_ptr = {head_q[IDX_W], rec_low};
        else                             rec_ptr = {~head_q[IDX_W], rec_low};
    end

    // Writeback eligibility: clean entries always accept, mispredicted ones only older ROB.
    always_comb begin
        wb_elig = '0;
        for (int p = 0; p < int'(WB_PORTS); p++) begin
            wb_elig[p] = i_wb_vld[p] & (~ent_mispred[i_wb_idx[p]] |
                                        older(i_wb_rob[p], ent_rob[i_wb_idx[p]]));
        end
    end

    // Same-index arbitration: oldest ROB wins, lowest port breaks exact ties.
    always_comb begin
        wb_win = wb_elig;
        for (int p = 0; p < int'(WB_PORTS); p++) begin
            for (int q = 0; q < int'(WB_PORTS); q++) begin
                if (q != p && wb_elig[q] && i_wb_idx[q] == i_wb_idx[p] &&
                    (older(i_wb_rob[q], i_wb_rob[p]) ||
                     (i_wb_rob[q] == i_wb_rob[p] && q < p))) begin
                    wb_win[p] = 1'b0;
                end
            end
        end
    end

    // Commit drain: trained entries wait for the update handshake, others pop at once.
    always_comb begin
        head_idx = head_q[IDX_W-1:0];
        cand     = (head_q != thre_q);
        if (ent_taken[head_idx]) new_ctr = (ent_ctr[head_idx] == 2'd3) ? 2'd3 : ent_ctr[head_idx] + 2'd1;
        else                     new_ctr = (ent_ctr[head_idx] == 2'd0) ? 2'd0 : ent_ctr[head_idx] - 2'd1;
        train = (ent_hit[head_idx] | ent_mispred[head_idx]) &
                (ent_mispred[head_idx] | (new_ctr != ent_ctr[head_idx]));
        o_upd_vld    = cand & train;
        pop          = cand & (~train | i_upd_done);
        o_upd_start  = ent_start[head_idx];
        o_upd_target = ent_target[head_idx];
        o_upd_taken  = ent_taken[head_idx];
        o_upd_ctr    = new_ctr;
    end

    // Pointer state and registered read ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_q  <= '0;
            fetch_q <= '0;
            head_q  <= '0;
            thre_q  <= '0;
            for (int r = 0; r < int'(RD_PORTS); r++) begin
                o_read_start[r] <= '0;
                o_read_next[r]  <= '0;
            end
        end else begin
            if (i_commit_vld) thre_q <= i_commit_ptr;
            if (pop) head_q <= head_q + ptr_t'(1);
            if (i_squash_vld) begin
                pred_q  <= thre_q;
                fetch_q <= thre_q;
            end else if (i_falsepred) begin
                pred_q  <= rec_ptr;
                fetch_q <= rec_ptr;
            end else begin
                if (enq)        pred_q  <= pred_q + ptr_t'(1);
                if (fetch_fire) fetch_q <= fetch_q + ptr_t'(1);
            end
            for (int r = 0; r < int'(RD_PORTS); r++) begin
                o_read_start[r] <= ent_start[i_read_idx[r]];
                o_read_next[r]  <= ent_next[i_read_idx[r]];
            end
        end
    end

    // Entry writes; later statements win, so enqueue overrides a same-slot writeback.
    always_ff @(posedge clk) begin
        for (int p = 0; p < int'(WB_PORTS); p++) begin
            if (wb_win[p]) begin
                ent_mispred[i_wb_idx[p]] <= i_wb_mispred[p];
                ent_taken[i_wb_idx[p]]   <= i_wb_taken[p];
                ent_target[i_wb_idx[p]]  <= i_wb_target[p];
                ent_rob[i_wb_idx[p]]     <= i_wb_rob[p];
            end
        end
        if (!i_squash_vld && i_falsepred) begin
            ent_next[i_recovery_idx]    <= i_recovery_npc;
            ent_mispred[i_recovery_idx] <= 1'b1;
        end
        if (enq) begin
            ent_start[pred_q[IDX_W-1:0]]   <= i_pred_start;
            ent_size[pred_q[IDX_W-1:0]]    <= i_pred_end[6:0] - i_pred_start[6:0];
            ent_taken[pred_q[IDX_W-1:0]]   <= i_pred_taken;
            ent_target[pred_q[IDX_W-1:0]]  <= i_pred_target;
            ent_next[pred_q[IDX_W-1:0]]    <= i_pred_taken ? i_pred_target : i_pred_end;
            ent_hit[pred_q[IDX_W-1:0]]     <= i_pred_hit;
            ent_ctr[pred_q[IDX_W-1:0]]     <= i_pred_ctr;
            ent_mispred[pred_q[IDX_W-1:0]] <= 1'b0;
            ent_rob[pred_q[IDX_W-1:0]]     <= '0;
        end
    end

endmodule

// File: tb/tb_ftq_gen2.sv
// Directed bench for ftq_gen2: vector tables for bypass fetch and counter training,
// hand-written sequences for full/wrap, falsepred, squash, writeback arbitration and
// update handshake hold.
module tb_ftq_gen2;

    logic        clk = 1'b0;
    logic        rst;
    logic        squash, falsepred;
    logic [3:0]  rec_idx;
    logic [63:0] rec_npc;
    logic        pred_req, ftq_rdy;
    logic [63:0] pred_start, pred_end, pred_target;
    logic        pred_taken, pred_hit;
    logic [1:0]  pred_ctr;
    logic        fetch_req;
    logic [3:0]  fetch_idx;
    logic        fetch_rdy;
    logic [63:0] fetch_start, fetch_next;
    logic [6:0]  fetch_size;
    logic [3:0]  read_idx [2];
    logic [63:0] read_start [2];
    logic [63:0] read_next [2];
    logic [1:0]  wb_vld;
    logic [3:0]  wb_idx [2];
    logic [6:0]  wb_rob [2];
    logic        wb_mispred [2];
    logic        wb_taken [2];
    logic [63:0] wb_target [2];
    logic        commit_vld;
    logic [4:0]  commit_ptr;
    logic        upd_vld, upd_done;
    logic [63:0] upd_start, upd_target;
    logic        upd_taken;
    logic [1:0]  upd_ctr;
    logic [4:0]  count;

    int checks = 0;
    int failures = 0;

    ftq_gen2 dut (
        .clk(clk), .rst(rst), .i_squash_vld(squash), .i_falsepred(falsepred),
        .i_recovery_idx(rec_idx), .i_recovery_npc(rec_npc),
        .i_pred_req(pred_req), .o_ftq_rdy(ftq_rdy), .i_pred_start(pred_start),
        .i_pred_end(pred_end), .i_pred_target(pred_target), .i_pred_taken(pred_taken),
        .i_pred_hit(pred_hit), .i_pred_ctr(pred_ctr),
        .o_fetch_req(fetch_req), .o_fetch_idx(fetch_idx), .i_fetch_rdy(fetch_rdy),
        .o_fetch_start(fetch_start), .o_fetch_next(fetch_next), .o_fetch_size(fetch_size),
        .i_read_idx(read_idx), .o_read_start(read_start), .o_read_next(read_next),
        .i_wb_vld(wb_vld), .i_wb_idx(wb_idx), .i_wb_rob(wb_rob), .i_wb_mispred(wb_mispred),
        .i_wb_taken(wb_taken), .i_wb_target(wb_target),
        .i_commit_vld(commit_vld), .i_commit_ptr(commit_ptr),
        .o_upd_vld(upd_vld), .i_upd_done(upd_done), .o_upd_start(upd_start),
        .o_upd_target(upd_target), .o_upd_taken(upd_taken), .o_upd_ctr(upd_ctr),
        .o_count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] start, fin, target;
        logic        taken;
        logic [63:0] exp_next;
        logic [6:0]  exp_size;
    } byp_t;

    typedef struct {
        logic       hit;
        logic [1:0] ctr;
        logic       taken;
        logic       exp_vld;
        logic [1:0] exp_ctr;
    } trn_t;

    byp_t byp [6];
    trn_t trn [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        squash = 0; falsepred = 0; rec_idx = 0; rec_npc = 0;
        pred_req = 0; pred_start = 0; pred_end = 0; pred_target = 0;
        pred_taken = 0; pred_hit = 0; pred_ctr = 0; fetch_rdy = 0;
        commit_vld = 0; commit_ptr = 0; upd_done = 0; wb_vld = 0;
        for (int i = 0; i < 2; i++) begin
            read_idx[i] = 0; wb_idx[i] = 0; wb_rob[i] = 0;
            wb_mispred[i] = 0; wb_taken[i] = 0; wb_target[i] = 0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic set_pred(input logic [63:0] s, input logic [63:0] e, input logic tk,
                            input logic [63:0] tg, input logic h, input logic [1:0] c);
        pred_req = 1; pred_start = s; pred_end = e; pred_taken = tk;
        pred_target = tg; pred_hit = h; pred_ctr = c;
    endtask

    task automatic push(input logic [63:0] s, input logic [63:0] e, input logic tk,
                        input logic [63:0] tg, input logic h, input logic [1:0] c);
        set_pred(s, e, tk, tg, h, c);
        tick();
        pred_req = 0;
    endtask

    task automatic wb(input int p, input logic [3:0] idx, input logic [6:0] rob,
                      input logic mp, input logic tk, input logic [63:0] tg);
        wb_vld[p] = 1; wb_idx[p] = idx; wb_rob[p] = rob;
        wb_mispred[p] = mp; wb_taken[p] = tk; wb_target[p] = tg;
    endtask

    task automatic commit(input logic [4:0] ptr);
        commit_vld = 1; commit_ptr = ptr;
        tick();
        commit_vld = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        byp[0] = '{64'h1000, 64'h1010, 64'h0,    1'b0, 64'h1010, 7'h10};
        byp[1] = '{64'h1010, 64'h1020, 64'h4000, 1'b1, 64'h4000, 7'h10};
        byp[2] = '{64'h4000, 64'h4008, 64'h5000, 1'b0, 64'h4008, 7'h08};
        byp[3] = '{64'h4008, 64'h4088, 64'h0,    1'b0, 64'h4088, 7'h00};
        byp[4] = '{64'h5000, 64'h507f, 64'h100,  1'b1, 64'h100,  7'h7f};
        byp[5] = '{64'h100,  64'h13c,  64'h0,    1'b0, 64'h13c,  7'h3c};

        trn[0] = '{1'b1, 2'd2, 1'b1, 1'b1, 2'd3};
        trn[1] = '{1'b1, 2'd3, 1'b1, 1'b0, 2'd3};
        trn[2] = '{1'b1, 2'd0, 1'b0, 1'b0, 2'd0};
        trn[3] = '{1'b1, 2'd3, 1'b0, 1'b1, 2'd2};
        trn[4] = '{1'b0, 2'd1, 1'b1, 1'b0, 2'd2};
        trn[5] = '{1'b1, 2'd1, 1'b0, 1'b1, 2'd0};

        // Reset state, sampled while reset is still held.
        clear_inputs();
        rst = 1;
        tick();
        tick();
        chk("rst_rdy", 64'(ftq_rdy), 64'd1);
        chk("rst_fetch_req", 64'(fetch_req), 64'd0);
        chk("rst_upd_vld", 64'(upd_vld), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_read_start0", read_start[0], 64'd0);
        chk("rst_read_next1", read_next[1], 64'd0);
        rst = 0;

        // Bypass fetch table: queue drained every cycle, so each pred issues same cycle.
        fetch_rdy = 1;
        for (int i = 0; i < 6; i++) begin
            set_pred(byp[i].start, byp[i].fin, byp[i].taken, byp[i].target, 1'b0, 2'd0);
            #1;
            chk($sformatf("byp%0d_req", i), 64'(fetch_req), 64'd1);
            chk($sformatf("byp%0d_idx", i), 64'(fetch_idx), 64'(i));
            chk($sformatf("byp%0d_start", i), fetch_start, byp[i].start);
            chk($sformatf("byp%0d_next", i), fetch_next, byp[i].exp_next);
            chk($sformatf("byp%0d_size", i), 64'(fetch_size), 64'(byp[i].exp_size));
            chk($sformatf("byp%0d_count", i), 64'(count), 64'(i));
            tick();
            pred_req = 0;
        end
        #1;
        chk("byp_idle_req", 64'(fetch_req), 64'd0);
        chk("byp_count6", 64'(count), 64'd6);
        read_idx[0] = 1; read_idx[1] = 4;
        tick();
        chk("read0_next", read_next[0], 64'h4000);
        chk("read1_start", read_start[1], 64'h5000);

        // Falsepred on entry 2 of 6.
        falsepred = 1; rec_idx = 2; rec_npc = 64'h2000;
        tick();
        falsepred = 0; read_idx[0] = 2;
        #1;
        chk("fp_count", 64'(count), 64'd3);
        chk("fp_fetch_req", 64'(fetch_req), 64'd0);
        tick();
        chk("fp_read_next", read_next[0], 64'h2000);
        chk("fp_read_start", read_start[0], 64'h4000);
        set_pred(64'h2000, 64'h2010, 1'b0, 64'h0, 1'b0, 2'd0);
        #1;
        chk("fp_bypass_req", 64'(fetch_req), 64'd1);
        chk("fp_bypass_idx", 64'(fetch_idx), 64'd3);
        tick();
        pred_req = 0;
        chk("fp_count_after", 64'(count), 64'd4);

        // Squash with thre = 2 and five entries.
        do_reset();
        for (int i = 0; i < 5; i++) push(64'(i * 16), 64'(i * 16 + 16), 1'b0, 64'h0, 1'b0, 2'd0);
        commit(5'd2);
        chk("sq_count_pre", 64'(count), 64'd5);
        squash = 1;
        tick();
        squash = 0;
        chk("sq_count1", 64'(count), 64'd1);
        chk("sq_fetch_req", 64'(fetch_req), 64'd0);
        tick();
        chk("sq_count0", 64'(count), 64'd0);
        tick();
        chk("sq_count_hold", 64'(count), 64'd0);
        set_pred(64'h3000, 64'h3010, 1'b0, 64'h0, 1'b0, 2'd0);
        #1;
        chk("sq_bypass_idx", 64'(fetch_idx), 64'd2);
        pred_req = 0;

        // Fill to 16, refused pushes while full, drain with wrapped thre.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_pred(64'(i * 16), 64'(i * 16 + 16), 1'b0, 64'h0, 1'b0, 2'd0);
            #1;
            chk($sformatf("fill%0d_rdy", i), 64'(ftq_rdy), 64'd1);
            tick();
        end
        chk("full_rdy", 64'(ftq_rdy), 64'd0);
        chk("full_count", 64'(count), 64'd16);
        commit_vld = 1; commit_ptr = 5'h10;
        tick();
        commit_vld = 0;
        chk("full_refused", 64'(count), 64'd16);
        tick();
        pred_req = 0;
        chk("full_pushpop", 64'(count), 64'd15);
        repeat (15) tick();
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_rdy", 64'(ftq_rdy), 64'd1);
        chk("drain_upd_vld", 64'(upd_vld), 64'd0);
        push(64'h9000, 64'h9010, 1'b0, 64'h0, 1'b0, 2'd0);
        chk("wrap_push_count", 64'(count), 64'd1);

        // Writeback arbitration, ROB age filtering, enqueue-over-writeback.
        do_reset();
        fetch_rdy = 1;
        push(64'h00, 64'h10, 1'b0, 64'h0, 1'b0, 2'd0);
        push(64'h10, 64'h20, 1'b0, 64'h0, 1'b0, 2'd0);
        wb(0, 4'd2, 7'h01, 1'b1, 1'b1, 64'hE2E0);
        push(64'h20, 64'h30, 1'b0, 64'h0, 1'b0, 2'd0);
        wb_vld = 0;
        push(64'h30, 64'h40, 1'b0, 64'h0, 1'b0, 2'd1);
        push(64'h40, 64'h50, 1'b0, 64'h0, 1'b0, 2'd0);
        wb(0, 4'd3, 7'h05, 1'b1, 1'b1, 64'hAAA0);
        wb(1, 4'd3, 7'h03, 1'b1, 1'b1, 64'hBBB0);
        tick();
        wb_vld = 0;
        wb(0, 4'd3, 7'h04, 1'b1, 1'b1, 64'hCCC0);
        tick();
        wb_vld = 0;
        wb(1, 4'd4, 7'h10, 1'b1, 1'b1, 64'h1110);
        tick();
        wb_vld = 0;
        wb(0, 4'd4, 7'h7F, 1'b1, 1'b1, 64'h7F70);
        tick();
        wb_vld = 0;
        wb(1, 4'd4, 7'h11, 1'b1, 1'b1, 64'h1170);
        tick();
        wb_vld = 0;
        commit(5'd5);
        for (int n = 0; n < 10 && !upd_vld; n++) tick();
        chk("wb3_upd_vld", 64'(upd_vld), 64'd1);
        chk("wb3_count", 64'(count), 64'd2);
        chk("wb3_start", upd_start, 64'h30);
        chk("wb3_target", upd_target, 64'hBBB0);
        chk("wb3_taken", 64'(upd_taken), 64'd1);
        chk("wb3_ctr", 64'(upd_ctr), 64'd2);
        upd_done = 1;
        tick();
        upd_done = 0;
        chk("wb4_upd_vld", 64'(upd_vld), 64'd1);
        chk("wb4_count", 64'(count), 64'd1);
        chk("wb4_target", upd_target, 64'h7F70);
        chk("wb4_ctr", 64'(upd_ctr), 64'd1);
        upd_done = 1;
        tick();
        upd_done = 0;
        chk("wb_drained", 64'(count), 64'd0);
        chk("wb_drained_vld", 64'(upd_vld), 64'd0);

        // Counter training table.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            push(64'h8000 + 64'(i * 16), 64'h8010 + 64'(i * 16), trn[i].taken, 64'h9000,
                 trn[i].hit, trn[i].ctr);
            commit(5'd1);
            chk($sformatf("trn%0d_vld", i), 64'(upd_vld), 64'(trn[i].exp_vld));
            chk($sformatf("trn%0d_ctr", i), 64'(upd_ctr), 64'(trn[i].exp_ctr));
            chk($sformatf("trn%0d_taken", i), 64'(upd_taken), 64'(trn[i].taken));
            upd_done = 1;
            tick();
            upd_done = 0;
            chk($sformatf("trn%0d_popped", i), 64'(count), 64'd0);
        end

        // Update held while done is low, squash does not cancel it.
        do_reset();
        push(64'h7000, 64'h7010, 1'b0, 64'h7100, 1'b1, 2'd2);
        wb(0, 4'd0, 7'h09, 1'b0, 1'b1, 64'h7200);
        tick();
        wb_vld = 0;
        commit(5'd1);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("hold%0d_vld", c), 64'(upd_vld), 64'd1);
            chk($sformatf("hold%0d_ctr", c), 64'(upd_ctr), 64'd3);
            chk($sformatf("hold%0d_target", c), upd_target, 64'h7200);
            chk($sformatf("hold%0d_start", c), upd_start, 64'h7000);
            chk($sformatf("hold%0d_count", c), 64'(count), 64'd1);
            squash = (c == 1);
            tick();
            squash = 0;
        end
        upd_done = 1;
        #1;
        chk("hold_done_vld", 64'(upd_vld), 64'd1);
        tick();
        upd_done = 0;
        chk("hold_popped", 64'(count), 64'd0);
        chk("hold_popped_vld", 64'(upd_vld), 64'd0);

        // Reset in the middle of an update.
        do_reset();
        push(64'h7000, 64'h7010, 1'b1, 64'h7100, 1'b1, 2'd1);
        commit(5'd1);
        chk("midrst_pre_vld", 64'(upd_vld), 64'd1);
        rst = 1;
        tick();
        rst = 0;
        chk("midrst_vld", 64'(upd_vld), 64'd0);
        chk("midrst_count", 64'(count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ftq_gen2.md
# ftq_gen2

Parametrised fetch target queue between the BPU, the instruction cache and the backend. It buffers predicted fetch blocks in a circular queue of DEPTH entries and issues them to the icache, bypassing the queue when it is empty. It accepts backend branch writebacks on WB_PORTS ports, arbitrating same-entry conflicts by ROB age. Committed entries drain in order, with an FTB update handshake per trained entry.

## Interface
- DEPTH, 16, entry count; power of two, at least 4; IDX_W = log2(DEPTH); pointers are IDX_W+1 bits (MSB = wrap bit)
- XLEN, 64, address width
- RD_PORTS, 2, backend address read ports
- WB_PORTS, 2, backend branch writeback ports
- ROB_W, 7, ROB index width; MSB is the ROB wrap bit
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- i_squash_vld  in  1  backend flush
- i_falsepred  in  1  predecode redirect; i_recovery_idx  in  IDX_W  entry to keep; i_recovery_npc  in  XLEN  corrected next address
- i_pred_req  in  1; o_ftq_rdy  out  1; i_pred_start, i_pred_end, i_pred_target  in  XLEN; i_pred_taken  in  1; i_pred_hit  in  1; i_pred_ctr  in  2
- o_fetch_req  out  1; o_fetch_idx  out  IDX_W; i_fetch_rdy  in  1; o_fetch_start, o_fetch_next  out  XLEN; o_fetch_size  out  7  (end − start, low 7 bits)
- i_read_idx[RD_PORTS]  in  IDX_W; o_read_start[RD_PORTS], o_read_next[RD_PORTS]  out  XLEN
- i_wb_vld  in  WB_PORTS; per port: i_wb_idx  IDX_W, i_wb_rob  ROB_W, i_wb_mispred  1, i_wb_taken  1, i_wb_target  XLEN
- i_commit_vld  in  1; i_commit_ptr  in  IDX_W+1  commit threshold (entries before it are committed)
- o_upd_vld  out  1; i_upd_done  in  1; o_upd_start, o_upd_target  out  XLEN; o_upd_taken  out  1; o_upd_ctr  out  2
- o_count  out  IDX_W+1  occupancy

## Operation
- Pointers: pred (tail), fetch, head, thre. count = pred − head (mod 2·DEPTH). Full when count == DEPTH. o_ftq_rdy = !full.
- Enqueue (enq) = i_pred_req & o_ftq_rdy & !i_falsepred & !i_squash_vld. The entry at pred is written with start, end, taken, target, hit and ctr; next = taken ? target : end; mispred and rob are cleared; pred increments.
- Fetch: o_fetch_req = (fetch != pred) | bypass, where bypass = enq & (fetch == pred). Under bypass, fetch outputs come combinationally from the i_pred_* inputs; otherwise from entry[fetch]. fetch increments on o_fetch_req & i_fetch_rdy.
- Falsepred:
  - entry[i_recovery_idx].next ← i_recovery_npc, and the entry is marked mispred.
  - pred and fetch ← the full pointer of i_recovery_idx + 1, wrap bit derived so that head ≤ pointer ≤ old pred.
  - Younger entries are discarded.
- Squash: pred and fetch ← thre. Entries in [head, thre) remain and continue to drain.
- Writeback:
  - A port is eligible if the entry is not mispred, or if i_wb_rob is older than the stored rob. older(a, b) = (a.msb != b.msb) ? a.low > b.low : a.low < b.low.
  - If several eligible ports target the same index, the oldest ROB index wins; the other ports are dropped.
  - The winner writes mispred, taken, target and rob.
- Read: o_read_* ← entry[i_read_idx] registered, 1-cycle latency.
- Commit:
  - i_commit_vld loads thre.
  - When head != thre, the head is the candidate. new_ctr = taken ? sat_inc(ctr) : sat_dec(ctr).
  - train = (hit | mispred) & (mispred | new_ctr != ctr).
  - If train: o_upd_vld = 1, and the head pops on i_upd_done. Otherwise the head pops immediately.
  - Update outputs: o_upd_start = head.start, o_upd_target = head.target, o_upd_taken = head.taken, o_upd_ctr = new_ctr.
- Priority: rst > squash > falsepred > enq. Pop, fetch and writeback proceed in parallel with all of these.

## Timing
- Reset values: all pointers 0; o_ftq_rdy = 1; o_fetch_req = 0; o_upd_vld = 0; o_count = 0; o_read_* = 0.
- Fetch, update and o_ftq_rdy outputs are combinational from state and inputs. Pointer and entry updates take effect at the next clock edge.
- Push and pop in the same cycle while full: the push is refused (rdy is computed before the pop).
- o_upd_vld and its payload are held stable until i_upd_done. Squash does not cancel an in-flight update.
- Writeback to a slot being enqueued in the same cycle: enq wins.
- Reset asserted mid-update drops o_upd_vld on the next cycle.

## Test plan
- Reset, then one pred with start 0x1000, end 0x1010, not taken, while empty → same-cycle o_fetch_req = 1, bypass, idx 0, size 0x10, next 0x1010; o_count = 1 next cycle.
- 16 preds with i_fetch_rdy = 0 → o_ftq_rdy = 0 after the 16th and o_count = 16. Then commit thre = 16 (wrap bit 1), 16 pops → o_count = 0; pointers wrap with the wrap bit set.
- Ports 0 and 1 write back mispred to entry 3 with rob 0x05 and 0x03 in the same cycle → stored rob = 0x03. A later writeback with rob 0x04 → rejected.
- Entry hit = 1, ctr = 2, taken writeback, commit → o_upd_vld with o_upd_ctr = 3; held for 3 cycles with i_upd_done = 0, pops on the cycle done = 1.
- 6 entries, falsepred idx 2 with npc 0x2000 → pred = fetch = 3, o_count = 3, read of idx 2 returns next = 0x2000.
- thre = 2, squash with 5 entries → pred = 2, entries 0–1 still drain, o_count reaches 0.
